// File: rtl/ns_link_arbiter_pkg.sv
// ns_link_arbiter_pkg: shared widths and arbiter state encoding for the ns link arbiter
package ns_link_arbiter_pkg;
  localparam int NS_ADDRESS_SIZE = 8;
  localparam int NS_DATA_SIZE = 8;
  localparam int NS_REDUN_SIZE = 4;
  typedef enum logic [1:0] {
    NS_ARB_IDLE  = 2'd0,
    NS_ARB_SEND  = 2'd1,
    NS_ARB_CLOSE = 2'd2
  } ns_arb_state_t;
endpackage

// File: rtl/ns_rr_pick.sv
// ns_rr_pick: combinational 4-way round-robin picker starting the scan at rr_ptr
module ns_rr_pick (
  input  logic [3:0] pending,
  input  logic [1:0] rr_ptr,
  output logic       valid,
  output logic [1:0] idx
);
  logic [3:0] rot;
  logic [1:0] off;
  always_comb begin
    rot = 4'({pending, pending} >> rr_ptr);
    off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    valid = |pending;
    idx = rr_ptr + off;
  end
endmodule

// File: rtl/ns_link_arbiter.sv
// ns_link_arbiter: merges four four-phase req/ack message links onto one output link
module ns_link_arbiter
  import ns_link_arbiter_pkg::*;
#(
  parameter int ASZ = NS_ADDRESS_SIZE,
  parameter int DSZ = NS_DATA_SIZE,
  parameter int RSZ = NS_REDUN_SIZE,
  parameter bit SYNC_EN = 1'b1
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic [3:0]       rcv_req,
  output logic [3:0]       rcv_ack,
  input  logic [4*ASZ-1:0] rcv_addr,
  input  logic [4*DSZ-1:0] rcv_data,
  input  logic [4*RSZ-1:0] rcv_red,
  output logic             snd_req,
  input  logic             snd_ack,
  output logic [ASZ-1:0]   snd_addr,
  output logic [DSZ-1:0]   snd_data,
  output logic [RSZ-1:0]   snd_red,
  output logic [1:0]       grant_idx,
  output logic             busy,
  output logic [7:0]       msg_cnt
);
  logic [3:0] req_s;
  logic ack_s;
  if (SYNC_EN) begin : g_sync
    logic [4:0] s1, s2;
    always_ff @(posedge i_clk or negedge reset)
      if (!reset) begin
        s1 <= '0;
        s2 <= '0;
      end else begin
        s1 <= {snd_ack, rcv_req};
        s2 <= s1;
      end
    assign {ack_s, req_s} = s2;
  end else begin : g_direct
    assign {ack_s, req_s} = {snd_ack, rcv_req};
  end
  ns_arb_state_t state;
  logic [1:0] rr_ptr;
  logic pick_valid;
  logic [1:0] pick_idx;
  ns_rr_pick u_pick (
    .pending(req_s & ~rcv_ack),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );
  assign busy = state != NS_ARB_IDLE;
  always_ff @(posedge i_clk or negedge reset)
    if (!reset) begin
      state <= NS_ARB_IDLE;
      rr_ptr <= '0;
      rcv_ack <= '0;
      snd_req <= 1'b0;
      snd_addr <= '0;
      snd_data <= '0;
      snd_red <= '0;
      grant_idx <= '0;
      msg_cnt <= '0;
    end else begin
      case (state)
        NS_ARB_IDLE:
          // a stray output ack in IDLE blocks new grants until it drops
          if (pick_valid && !ack_s) begin
            state <= NS_ARB_SEND;
            rcv_ack <= 4'b0001 << pick_idx;
            grant_idx <= pick_idx;
            snd_addr <= rcv_addr[pick_idx*ASZ +: ASZ];
            snd_data <= rcv_data[pick_idx*DSZ +: DSZ];
            snd_red <= rcv_red[pick_idx*RSZ +: RSZ];
          end
        NS_ARB_SEND: begin
          snd_req <= !ack_s;
          if (ack_s) state <= NS_ARB_CLOSE;
        end
        NS_ARB_CLOSE:
          if (!ack_s && !req_s[grant_idx]) begin
            state <= NS_ARB_IDLE;
            rcv_ack <= '0;
            rr_ptr <= grant_idx + 2'd1;
            msg_cnt <= msg_cnt + 8'd1;
          end
        default: state <= NS_ARB_IDLE;
      endcase
    end
endmodule
